// File: rtl/lcd_frame_scheduler.sv
// Sequences HD44780 power-up/init, then sweeps char index 0..31 across two rows per frame.
// Optional build macro MODE_CLEAR_EN: clear the panel before the first frame after a mode change.
module lcd_frame_scheduler #(
  parameter int PWR_WAIT  = 50000,
  parameter int E_HIGH    = 10,
  parameter int CMD_WAIT  = 2000,
  parameter int CLR_WAIT  = 80000,
  parameter int NUM_MODES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic [7:0] char_m0,
  input  logic [7:0] char_m1,
  input  logic [7:0] char_m2,
  input  logic [7:0] char_m3,
  output logic [4:0] index,
  output logic [1:0] mode_sel,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       frame_done
);

  localparam int MAX_AB = (PWR_WAIT > CLR_WAIT) ? PWR_WAIT : CLR_WAIT;
  localparam int MAX_CD = (CMD_WAIT > E_HIGH) ? CMD_WAIT : E_HIGH;
  localparam int MAXW   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAXW + 1);

  typedef enum logic [2:0] {S_PWR, S_INIT, S_ADDR, S_FETCH, S_WRITE, S_CLR} state_t;
  typedef enum logic [1:0] {P_SETUP, P_EH, P_WT} phase_t;

  state_t        state;
  phase_t        ph;
  logic [CW-1:0] cnt;
  logic [1:0]    init_idx;
  logic          pend;

  logic [7:0]    char_sel;
  logic [CW-1:0] wait_len;
  logic [1:0]    mode_next;
  logic          in_write, wr_done, apply;

  function automatic logic [7:0] init_cmd(input logic [1:0] i);
    case (i)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  always_comb begin
    case (mode_sel)
      2'd0:    char_sel = char_m0;
      2'd1:    char_sel = char_m1;
      2'd2:    char_sel = char_m2;
      default: char_sel = char_m3;
    endcase
  end

  // Only a clear command (rs=0, 0x01) earns the long wait; data byte 0x01 does not.
  assign wait_len  = (!lcd_rs && lcd_data == 8'h01) ? CW'(CLR_WAIT - 1) : CW'(CMD_WAIT - 1);
  assign mode_next = (mode_sel == 2'(NUM_MODES - 1)) ? 2'd0 : mode_sel + 2'd1;
  assign in_write  = (state == S_INIT) || (state == S_ADDR) || (state == S_WRITE) || (state == S_CLR);
  assign wr_done   = in_write && (ph == P_WT) && (cnt == '0);
  assign apply     = pend | btn_mode;
  assign lcd_rw    = 1'b0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_PWR;
      ph         <= P_SETUP;
      cnt        <= '0;
      init_idx   <= '0;
      pend       <= 1'b0;
      index      <= '0;
      mode_sel   <= '0;
      lcd_rs     <= 1'b0;
      lcd_e      <= 1'b0;
      lcd_data   <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (btn_mode) pend <= 1'b1;

      // Byte write primitive: setup -> E high -> E low wait; rs/data held throughout.
      if (in_write && !wr_done) begin
        case (ph)
          P_SETUP: begin
            lcd_e <= 1'b1;
            ph    <= P_EH;
            cnt   <= CW'(E_HIGH - 1);
          end
          P_EH: begin
            if (cnt == '0) begin
              lcd_e <= 1'b0;
              ph    <= P_WT;
              cnt   <= wait_len;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: cnt <= cnt - CW'(1);
        endcase
      end

      case (state)
        S_PWR: begin
          if (cnt == CW'(PWR_WAIT - 1)) begin
            state    <= S_INIT;
            init_idx <= 2'd0;
            ph       <= P_SETUP;
            lcd_rs   <= 1'b0;
            lcd_data <= init_cmd(2'd0);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_INIT: begin
          if (wr_done) begin
            ph     <= P_SETUP;
            lcd_rs <= 1'b0;
            if (init_idx == 2'd3) begin
              state    <= S_ADDR;
              lcd_data <= 8'h80;
            end else begin
              init_idx <= init_idx + 2'd1;
              lcd_data <= init_cmd(init_idx + 2'd1);
            end
          end
        end
        S_CLR: begin
          if (wr_done) begin
            state    <= S_ADDR;
            ph       <= P_SETUP;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h80;
          end
        end
        S_ADDR: begin
          if (wr_done) begin
            state <= S_FETCH;
            cnt   <= '0;
          end
        end
        S_FETCH: begin
          // Two cycles: index reaches the source register, then its output settles.
          if (cnt == CW'(1)) begin
            state    <= S_WRITE;
            ph       <= P_SETUP;
            lcd_rs   <= 1'b1;
            lcd_data <= char_sel;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WRITE: begin
          if (wr_done) begin
            if (index == 5'd15) begin
              index    <= 5'd16;
              state    <= S_ADDR;
              ph       <= P_SETUP;
              lcd_rs   <= 1'b0;
              lcd_data <= 8'hC0;
            end else if (index == 5'd31) begin
              frame_done <= 1'b1;
              index      <= 5'd0;
              ph         <= P_SETUP;
              lcd_rs     <= 1'b0;
              if (apply) begin
                mode_sel <= mode_next;
                pend     <= 1'b0;
              end
`ifdef MODE_CLEAR_EN
              if (apply) begin
                state    <= S_CLR;
                lcd_data <= 8'h01;
              end else begin
                state    <= S_ADDR;
                lcd_data <= 8'h80;
              end
`else
              state    <= S_ADDR;
              lcd_data <= 8'h80;
`endif
            end else begin
              index <= index + 5'd1;
              state <= S_FETCH;
              cnt   <= '0;
            end
          end
        end
        default: state <= S_PWR;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_scheduler.sv
// Directed bench for lcd_frame_scheduler with short timing parameters and NUM_MODES=3.
module tb_lcd_frame_scheduler;
  localparam int PW = 20, EH = 2, CMDW = 5, CLW = 12, NM = 3;
`ifdef MODE_CLEAR_EN
  localparam int OFS = 1;
`else
  localparam int OFS = 0;
`endif

  logic       clk = 1'b0, rst = 1'b0, btn_mode = 1'b0, pat = 1'b0;
  logic [7:0] char_m0, char_m1, char_m2, char_m3;
  logic [4:0] index;
  logic [1:0] mode_sel;
  logic       lcd_rs, lcd_rw, lcd_e, frame_done;
  logic [7:0] lcd_data;

  int checks = 0, fails = 0;

  lcd_frame_scheduler #(.PWR_WAIT(PW), .E_HIGH(EH), .CMD_WAIT(CMDW), .CLR_WAIT(CLW), .NUM_MODES(NM)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode),
    .char_m0(char_m0), .char_m1(char_m1), .char_m2(char_m2), .char_m3(char_m3),
    .index(index), .mode_sel(mode_sel), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_data(lcd_data), .frame_done(frame_done));

  always #5 clk = ~clk;

  // Mode sources: registered one cycle after index.
  always @(posedge clk) begin
    char_m0 <= pat ? 8'h41 : 8'h40 + {3'b000, index};
    char_m1 <= pat ? 8'h42 : 8'h40 + {3'b000, index};
    char_m2 <= pat ? 8'h43 : 8'h40 + {3'b000, index};
    char_m3 <= 8'hEE;
  end

  // Write log: {rs, data} captured on every E rising edge.
  logic [8:0] wlog[$];
  logic e_q = 1'b0, fd_q = 1'b0;
  int fd_cnt = 0, fd_wr = 0, fd_long = 0;
  always @(negedge clk) begin
    e_q  <= lcd_e;
    fd_q <= frame_done;
    if (lcd_e && !e_q) wlog.push_back({lcd_rs, lcd_data});
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_wr  <= wlog.size();
      if (fd_q) fd_long <= fd_long + 1;
    end
  end

  task automatic wait_wr(input int n, output bit ok);
    int k = 0;
    while (wlog.size() < n && k < 3000) begin @(negedge clk); k++; end
    ok = (wlog.size() >= n);
  endtask

  task automatic pulse_btn();
    btn_mode = 1'b1; @(negedge clk); btn_mode = 1'b0;
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({index, mode_sel, lcd_rs, lcd_rw, lcd_e, lcd_data, frame_done} !== 19'h0) begin
      fails++;
      $display("FAIL reset_vals got idx=%0d mode=%0d rs=%b rw=%b e=%b data=%h fd=%b want all 0",
               index, mode_sel, lcd_rs, lcd_rw, lcd_e, lcd_data, frame_done);
    end
    rst = 1'b1;
    while (n < 100) begin @(negedge clk); n++; if (lcd_e) break; end
    // PW wait cycles plus one setup cycle before E rises.
    checks++;
    if (n != PW + 1) begin fails++; $display("FAIL pwr_wait got %0d want %0d", n, PW + 1); end
  endtask

  task automatic test_init();
    int k = 0, gap = 0;
    bit ok;
    logic [8:0] exp [5];
    exp = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h080};
    while ((!lcd_e || lcd_data != 8'h01) && k < 500) begin @(negedge clk); k++; end
    while (lcd_e && k < 500) begin @(negedge clk); k++; end
    while (!lcd_e && lcd_data == 8'h01 && !lcd_rs && k < 500) begin gap++; @(negedge clk); k++; end
    checks++;
    if (gap != CLW) begin fails++; $display("FAIL clr_gap got %0d want %0d", gap, CLW); end
    wait_wr(5, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL init_timeout got %0d writes want 5", wlog.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wlog[i] !== exp[i]) begin fails++; $display("FAIL init_cmd%0d got %h want %h", i, wlog[i], exp[i]); end
    end
  endtask

  task automatic test_frame();
    bit ok;
    int bad0 = 0, bad1 = 0;
    wait_wr(38, ok);
    pat = 1'b1;
    wait_wr(39, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL frame_timeout got %0d writes want 39", wlog.size()); end
    for (int i = 0; i < 16; i++) begin
      if (wlog[5 + i]  !== {1'b1, 8'h40 + 8'(i)}) bad0++;
      if (wlog[22 + i] !== {1'b1, 8'h50 + 8'(i)}) bad1++;
    end
    checks++;
    if (bad0 != 0) begin fails++; $display("FAIL row0_data got %0d bad want 0", bad0); end
    checks++;
    if (wlog[21] !== 9'h0C0) begin fails++; $display("FAIL row1_addr got %h want 0c0", wlog[21]); end
    checks++;
    if (bad1 != 0) begin fails++; $display("FAIL row1_data got %0d bad want 0", bad1); end
    checks++;
    if (wlog[38] !== 9'h080) begin fails++; $display("FAIL next_frame_addr got %h want 080", wlog[38]); end
    checks++;
    if (fd_cnt != 1 || fd_wr != 38 || fd_long != 0) begin
      fails++;
      $display("FAIL frame_done got cnt=%0d at_wr=%0d long=%0d want 1/38/0", fd_cnt, fd_wr, fd_long);
    end
  endtask

  task automatic test_mode_change();
    bit ok;
    int k = 0, gap = 0, bad2 = 0, bad3 = 0;
    wait_wr(48, ok);
    checks++;
    if (mode_sel !== 2'd0) begin fails++; $display("FAIL mode_mid got %0d want 0", mode_sel); end
    pulse_btn();
    repeat (30) @(negedge clk);
    pulse_btn();
    while (!frame_done && k < 1000) begin @(negedge clk); k++; end
    checks++;
    if (!frame_done || mode_sel !== 2'd1) begin
      fails++; $display("FAIL mode_at_end got fd=%b mode=%0d want 1/1", frame_done, mode_sel);
    end
`ifdef MODE_CLEAR_EN
    while ((!lcd_e || lcd_data != 8'h01) && k < 1000) begin @(negedge clk); k++; end
    while (lcd_e && k < 1000) begin @(negedge clk); k++; end
    while (!lcd_e && lcd_data == 8'h01 && k < 1000) begin gap++; @(negedge clk); k++; end
    checks++;
    if (gap != CLW) begin fails++; $display("FAIL mode_clr_gap got %0d want %0d", gap, CLW); end
`endif
    wait_wr(106 + OFS, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL mode_timeout got %0d writes want %0d", wlog.size(), 106 + OFS); end
    for (int i = 0; i < 16; i++) begin
      if (wlog[39 + i] !== 9'h141 || wlog[56 + i] !== 9'h141) bad2++;
      if (wlog[73 + OFS + i] !== 9'h142 || wlog[90 + OFS + i] !== 9'h142) bad3++;
    end
    checks++;
    if (bad2 != 0) begin fails++; $display("FAIL old_mode_frame got %0d bad want 0", bad2); end
    checks++;
    if (wlog[72] !== (OFS ? 9'h001 : 9'h080)) begin
      fails++; $display("FAIL frame_start got %h want %h", wlog[72], OFS ? 9'h001 : 9'h080);
    end
    checks++;
    if (bad3 != 0) begin fails++; $display("FAIL new_mode_frame got %0d bad want 0", bad3); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    bit ok;
    logic [8:0] exp [5];
    exp = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h080};
    while (!(lcd_e && lcd_rs && index == 5'd9) && k < 1000) begin @(negedge clk); k++; end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({index, mode_sel, lcd_rs, lcd_rw, lcd_e, lcd_data, frame_done} !== 19'h0) begin
      fails++;
      $display("FAIL mid_reset got idx=%0d mode=%0d rs=%b e=%b data=%h want all 0",
               index, mode_sel, lcd_rs, lcd_e, lcd_data);
    end
    rst = 1'b1;
    wlog.delete();
    wait_wr(5, ok);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (wlog[i] !== exp[i]) begin fails++; $display("FAIL reinit_cmd%0d got %h want %h", i, wlog[i], exp[i]); end
    end
  endtask

  task automatic test_mode_wrap();
    logic [1:0] exp [4];
    exp = '{2'd1, 2'd2, 2'd0, 2'd1};
    for (int p = 0; p < 4; p++) begin
      int k = 0;
      while (index != 5'd5 && k < 2000) begin @(negedge clk); k++; end
      pulse_btn();
      while (!frame_done && k < 2000) begin @(negedge clk); k++; end
      checks++;
      if (mode_sel !== exp[p]) begin fails++; $display("FAIL wrap%0d got %0d want %0d", p, mode_sel, exp[p]); end
      @(negedge clk);
    end
  endtask

  task automatic test_frame_end_btn();
    int k = 0;
    while (!(lcd_e && lcd_rs && index == 5'd31) && k < 2000) begin @(negedge clk); k++; end
    while (lcd_e && k < 2000) begin @(negedge clk); k++; end
    // First wait cycle seen; the frame ends on the edge after the last of CMDW wait cycles.
    repeat (CMDW - 1) @(negedge clk);
    btn_mode = 1'b1;
    @(negedge clk);
    btn_mode = 1'b0;
    checks++;
    if (!frame_done || mode_sel !== 2'd2) begin
      fails++; $display("FAIL same_cycle_btn got fd=%b mode=%0d want 1/2", frame_done, mode_sel);
    end
    k = 0;
    @(negedge clk);
    while (!frame_done && k < 2000) begin @(negedge clk); k++; end
    checks++;
    if (!frame_done || mode_sel !== 2'd2) begin
      fails++; $display("FAIL pend_cleared got fd=%b mode=%0d want 1/2", frame_done, mode_sel);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_frame();
    test_mode_change();
    test_reset_mid();
    test_mode_wrap();
    test_frame_end_btn();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
